// File: rtl/keypad_matrix_emulator.sv
// 4x4 membrane keypad stand-in: replays one scripted key press (bounce-in, hold, bounce-out, gap)
// and answers the scanner's active-low column drive with active-low row sense, combinationally.
module keypad_matrix_emulator #(
  parameter int BOUNCE_CYCLES = 8,
  parameter int GAP_CYCLES    = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [3:0]  iCOL,
  output logic [3:0]  oROW,
  input  logic        iCMD_VALID,
  output logic        oCMD_READY,
  input  logic [3:0]  iCMD_KEY,
  input  logic [15:0] iCMD_HOLD,
  output logic        oBUSY,
  output logic        oDONE
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  localparam bit          LP_HAS_BOUNCE = (BOUNCE_CYCLES > 0);
  localparam bit          LP_HAS_GAP    = (GAP_CYCLES > 0);
  localparam logic [15:0] LP_BOUNCE_M1  = (BOUNCE_CYCLES > 0) ? 16'(BOUNCE_CYCLES - 1) : 16'd0;
  localparam logic [15:0] LP_GAP_M1     = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic        r_contact;
  logic        w_contact_next;
  logic [1:0]  r_row_idx;
  logic [1:0]  r_col_idx;
  logic [15:0] r_hold_m1;
  logic        r_done;
  logic        w_done_next;
  logic        w_accept;
  logic [1:0]  w_key_row;
  logic [1:0]  w_key_col;
  logic [15:0] w_hold_m1;
  logic [3:0]  w_row;

  // Handshake: a command transfers on a rising edge where iCMD_VALID and oCMD_READY are both high;
  // oCMD_READY is high exactly in IDLE, and command inputs are ignored on every other edge.
  assign w_accept   = iCMD_VALID && (r_state == ST_IDLE);
  assign oCMD_READY = (r_state == ST_IDLE);
  assign oBUSY      = (r_state != ST_IDLE);
  assign oDONE      = r_done;
  assign w_hold_m1  = (iCMD_HOLD == 16'd0) ? 16'd0 : (iCMD_HOLD - 16'd1);

  always_comb begin
    w_key_row = 2'd0;
    w_key_col = 2'd0;
    case (iCMD_KEY)
      4'h1: begin w_key_row = 2'd0; w_key_col = 2'd0; end
      4'h2: begin w_key_row = 2'd0; w_key_col = 2'd1; end
      4'h3: begin w_key_row = 2'd0; w_key_col = 2'd2; end
      4'hA: begin w_key_row = 2'd0; w_key_col = 2'd3; end
      4'h4: begin w_key_row = 2'd1; w_key_col = 2'd0; end
      4'h5: begin w_key_row = 2'd1; w_key_col = 2'd1; end
      4'h6: begin w_key_row = 2'd1; w_key_col = 2'd2; end
      4'hB: begin w_key_row = 2'd1; w_key_col = 2'd3; end
      4'h7: begin w_key_row = 2'd2; w_key_col = 2'd0; end
      4'h8: begin w_key_row = 2'd2; w_key_col = 2'd1; end
      4'h9: begin w_key_row = 2'd2; w_key_col = 2'd2; end
      4'hC: begin w_key_row = 2'd2; w_key_col = 2'd3; end
      4'h0: begin w_key_row = 2'd3; w_key_col = 2'd0; end
      4'hF: begin w_key_row = 2'd3; w_key_col = 2'd1; end
      4'hE: begin w_key_row = 2'd3; w_key_col = 2'd2; end
      4'hD: begin w_key_row = 2'd3; w_key_col = 2'd3; end
    endcase
  end

  // The contact bit is the next-cycle value: set on state entry, toggled while chattering.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_contact_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_contact_next = 1'b1;
          if (LP_HAS_BOUNCE) begin
            w_state_next = ST_BOUNCE_IN;
            w_cnt_next   = LP_BOUNCE_M1;
          end else begin
            w_state_next = ST_HOLD;
            w_cnt_next   = w_hold_m1;
          end
        end
      end
      ST_BOUNCE_IN: begin
        if (r_cnt == 16'd0) begin
          w_state_next   = ST_HOLD;
          w_cnt_next     = r_hold_m1;
          w_contact_next = 1'b1;
        end else begin
          w_cnt_next     = r_cnt - 16'd1;
          w_contact_next = ~r_contact;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 16'd0) begin
          if (LP_HAS_BOUNCE) begin
            w_state_next = ST_BOUNCE_OUT;
            w_cnt_next   = LP_BOUNCE_M1;
          end else if (LP_HAS_GAP) begin
            w_state_next = ST_GAP;
            w_cnt_next   = LP_GAP_M1;
          end else begin
            w_state_next = ST_IDLE;
            w_cnt_next   = 16'd0;
          end
        end else begin
          w_cnt_next     = r_cnt - 16'd1;
          w_contact_next = 1'b1;
        end
      end
      ST_BOUNCE_OUT: begin
        if (r_cnt == 16'd0) begin
          if (LP_HAS_GAP) begin
            w_state_next = ST_GAP;
            w_cnt_next   = LP_GAP_M1;
          end else begin
            w_state_next = ST_IDLE;
            w_cnt_next   = 16'd0;
          end
        end else begin
          w_cnt_next     = r_cnt - 16'd1;
          w_contact_next = ~r_contact;
        end
      end
      ST_GAP: begin
        if (r_cnt == 16'd0) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 16'd0;
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 16'd0;
      end
    endcase
  end

  assign w_done_next = (r_state != ST_IDLE) && (w_state_next == ST_IDLE);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 16'd0;
      r_contact <= 1'b0;
      r_row_idx <= 2'd0;
      r_col_idx <= 2'd0;
      r_hold_m1 <= 16'd0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_contact <= w_contact_next;
      r_done    <= w_done_next;
      if (w_accept) begin
        r_row_idx <= w_key_row;
        r_col_idx <= w_key_col;
        r_hold_m1 <= w_hold_m1;
      end
    end
  end

  // Row sense follows the live column drive with no register in the path, like a real switch.
  always_comb begin
    w_row = 4'hF;
    if (r_contact && !iCOL[r_col_idx]) begin
      w_row[r_row_idx] = 1'b0;
    end
  end

  assign oROW = w_row;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: one clean-edge instance (no bounce, no gap) and one with
// default timing, checked cycle by cycle against an expected {busy, done, row} queue.
module tb_keypad_matrix_emulator;

  logic        iclk;
  logic        rst_n;
  logic [3:0]  col0, col1, key0, key1;
  logic [15:0] hold0, hold1;
  logic        v0, v1;
  logic [3:0]  row0, row1;
  logic        rdy0, rdy1, busy0, busy1, done0, done1;

  logic [5:0]  exp_q[$];
  int          n_pass;
  int          n_total;

  keypad_matrix_emulator #(.BOUNCE_CYCLES(0), .GAP_CYCLES(0)) u_clean (
    .iCLK(iclk), .iRST(rst_n), .iCOL(col0), .oROW(row0),
    .iCMD_VALID(v0), .oCMD_READY(rdy0), .iCMD_KEY(key0), .iCMD_HOLD(hold0),
    .oBUSY(busy0), .oDONE(done0)
  );

  keypad_matrix_emulator u_dflt (
    .iCLK(iclk), .iRST(rst_n), .iCOL(col1), .oROW(row1),
    .iCMD_VALID(v1), .oCMD_READY(rdy1), .iCMD_KEY(key1), .iCMD_HOLD(hold1),
    .oBUSY(busy1), .oDONE(done1)
  );

  // Clock / reset
  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Expected row sense from the physical keypad layout, read row by row.
  function automatic logic [3:0] exp_row(input logic [3:0] key, input bit contact,
                                         input logic [3:0] col);
    logic [3:0] layout [16];
    logic [3:0] r;
    layout = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    r = 4'hF;
    for (int idx = 0; idx < 16; idx++) begin
      if (layout[idx] == key && contact && col[idx % 4] == 1'b0) r[idx / 4] = 1'b0;
    end
    return r;
  endfunction

  function automatic void push_seq(input logic [3:0] key, input logic [15:0] hold,
                                   input logic [3:0] col, input int b, input int g);
    int h;
    h = (hold == 16'd0) ? 1 : int'(hold);
    for (int i = 0; i < b; i++) exp_q.push_back({2'b10, exp_row(key, (i % 2) == 0, col)});
    for (int i = 0; i < h; i++) exp_q.push_back({2'b10, exp_row(key, 1'b1, col)});
    for (int i = 0; i < b; i++) exp_q.push_back({2'b10, exp_row(key, (i % 2) == 1, col)});
    for (int i = 0; i < g; i++) exp_q.push_back({2'b10, 4'hF});
    exp_q.push_back({2'b01, 4'hF});
  endfunction

  // Driver: presents a command from the falling edge so the next rising edge can accept it.
  task automatic drive_cmd(input bit sel, input logic [3:0] key, input logic [15:0] hold,
                           input logic [3:0] col);
    @(negedge iclk);
    if (!sel) begin
      v0 = 1'b1; key0 = key; hold0 = hold; col0 = col;
    end else begin
      v1 = 1'b1; key1 = key; hold1 = hold; col1 = col;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    col0 = 4'h0; col1 = 4'h0;
    #3;
    n_total += 8;
    if (row0 !== 4'hF) $display("FAIL reset_row0: got %h expected f", row0); else n_pass++;
    if (rdy0 !== 1'b1) $display("FAIL reset_rdy0: got %b expected 1", rdy0); else n_pass++;
    if (busy0 !== 1'b0) $display("FAIL reset_busy0: got %b expected 0", busy0); else n_pass++;
    if (done0 !== 1'b0) $display("FAIL reset_done0: got %b expected 0", done0); else n_pass++;
    if (row1 !== 4'hF) $display("FAIL reset_row1: got %h expected f", row1); else n_pass++;
    if (rdy1 !== 1'b1) $display("FAIL reset_rdy1: got %b expected 1", rdy1); else n_pass++;
    if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b expected 0", busy1); else n_pass++;
    if (done1 !== 1'b0) $display("FAIL reset_done1: got %b expected 0", done1); else n_pass++;
    repeat (2) @(negedge iclk);
    rst_n = 1'b1;
    col0 = 4'hF; col1 = 4'hF;
  endtask

  task automatic test_clean_edges();
    logic [3:0] cols [2];
    logic [5:0] exp;
    logic [5:0] got;
    int n;
    cols = '{4'b1110, 4'b1101};
    for (int t = 0; t < 2; t++) begin
      push_seq(4'h0, 16'd5, cols[t], 0, 0);
      drive_cmd(1'b0, 4'h0, 16'd5, cols[t]);
      n_total++;
      if (rdy0 !== 1'b1) $display("FAIL clean_ready[%0d]: got %b expected 1", t, rdy0); else n_pass++;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
        @(negedge iclk);
        if (i == 0) v0 = 1'b0;
        exp = exp_q.pop_front();
        got = {busy0, done0, row0};
        n_total++;
        if (got !== exp) $display("FAIL clean_seq%0d[%0d]: got %h expected %h", t, i, got, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bounce_default();
    logic [3:0]  key;
    logic [15:0] hold;
    logic [3:0]  col;
    logic [5:0]  exp;
    logic [5:0]  got;
    int n;
    for (int t = 0; t < 4; t++) begin
      if (t == 0) begin
        key = 4'h8; hold = 16'd10; col = 4'b1101;
      end else begin
        key  = 4'($urandom_range(0, 15));
        hold = 16'($urandom_range(0, 6));
        col  = 4'($urandom_range(0, 15));
      end
      push_seq(key, hold, col, 8, 16);
      drive_cmd(1'b1, key, hold, col);
      n_total++;
      if (rdy1 !== 1'b1) $display("FAIL dflt_ready[%0d]: got %b expected 1", t, rdy1); else n_pass++;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
        @(negedge iclk);
        if (i == 0) v1 = 1'b0;
        exp = exp_q.pop_front();
        got = {busy1, done1, row1};
        n_total++;
        if (got !== exp) $display("FAIL dflt_seq%0d_key%h[%0d]: got %h expected %h", t, key, i, got, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_live_scan();
    logic [3:0] rot [4];
    logic [5:0] exp;
    logic [5:0] got;
    rot = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    drive_cmd(1'b0, 4'hA, 16'd12, 4'b1110);
    for (int i = 0; i < 12; i++) begin
      @(negedge iclk);
      if (i == 0) v0 = 1'b0;
      for (int s = 0; s < 2; s++) begin
        col0 = rot[(i + s) % 4];
        exp_q.push_back({2'b10, exp_row(4'hA, 1'b1, col0)});
        #1;
        exp = exp_q.pop_front();
        got = {busy0, done0, row0};
        n_total++;
        if (got !== exp) $display("FAIL live_scan[%0d.%0d] col=%b: got %h expected %h", i, s, col0, got, exp);
        else n_pass++;
      end
    end
    @(negedge iclk);
    exp_q.push_back({2'b01, 4'hF});
    exp = exp_q.pop_front();
    got = {busy0, done0, row0};
    n_total++;
    if (got !== exp) $display("FAIL live_scan_done: got %h expected %h", got, exp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    logic [5:0] got;
    int n1;
    int n;
    push_seq(4'h6, 16'd3, 4'b0000, 8, 16);
    n1 = exp_q.size();
    push_seq(4'hA, 16'd0, 4'b0000, 8, 16);
    n = exp_q.size();
    drive_cmd(1'b1, 4'h6, 16'd3, 4'b0000);
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      if (i == 0) begin
        key1 = 4'hA; hold1 = 16'd0;
      end
      if (i == n1) v1 = 1'b0;
      if (i == n1 - 1) begin
        n_total++;
        if (rdy1 !== 1'b1) $display("FAIL b2b_ready_in_done: got %b expected 1", rdy1); else n_pass++;
      end
      exp = exp_q.pop_front();
      got = {busy1, done1, row1};
      n_total++;
      if (got !== exp) $display("FAIL b2b_seq[%0d]: got %h expected %h", i, got, exp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] exp;
    logic [5:0] got;
    int n;
    push_seq(4'h6, 16'd20, 4'b1011, 8, 16);
    drive_cmd(1'b1, 4'h6, 16'd20, 4'b1011);
    for (int i = 0; i < 13; i++) begin
      @(negedge iclk);
      if (i == 0) v1 = 1'b0;
      exp = exp_q.pop_front();
      got = {busy1, done1, row1};
      n_total++;
      if (got !== exp) $display("FAIL rst_pre[%0d]: got %h expected %h", i, got, exp); else n_pass++;
    end
    exp_q.delete();
    #1 rst_n = 1'b0;
    #1;
    n_total += 4;
    if (row1 !== 4'hF) $display("FAIL rst_async_row: got %h expected f", row1); else n_pass++;
    if (busy1 !== 1'b0) $display("FAIL rst_async_busy: got %b expected 0", busy1); else n_pass++;
    if (rdy1 !== 1'b1) $display("FAIL rst_async_ready: got %b expected 1", rdy1); else n_pass++;
    if (done1 !== 1'b0) $display("FAIL rst_async_done: got %b expected 0", done1); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge iclk);
      n_total++;
      if ({done1, row1} !== 5'h0F) $display("FAIL rst_hold[%0d]: got %h expected 0f", i, {done1, row1});
      else n_pass++;
    end
    @(negedge iclk);
    rst_n = 1'b1;
    v1 = 1'b1; key1 = 4'h5; hold1 = 16'd2; col1 = 4'b1101;
    push_seq(4'h5, 16'd2, 4'b1101, 8, 16);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      if (i == 0) v1 = 1'b0;
      exp = exp_q.pop_front();
      got = {busy1, done1, row1};
      n_total++;
      if (got !== exp) $display("FAIL rst_post[%0d]: got %h expected %h", i, got, exp); else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    v0 = 1'b0; v1 = 1'b0;
    key0 = 4'h0; key1 = 4'h0;
    hold0 = 16'd0; hold1 = 16'd0;
    col0 = 4'hF; col1 = 4'hF;
    rst_n = 1'b1;
    test_reset();
    test_clean_edges();
    test_bounce_default();
    test_live_scan();
    test_back_to_back();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
